// File: rtl/slice_sched_pkg.sv
// Shared types and default frame geometry for the slice ring scheduler.
package slice_sched_pkg;

  localparam int unsigned IMAGE_WIDTH  = 40;
  localparam int unsigned IMAGE_HEIGHT = 48;
  localparam int unsigned SLOT_SIZE    = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned NUM_SLOTS    = 18;

  typedef enum logic {
    WIdle = 1'b0,
    WHeld = 1'b1
  } w_state_e;

  typedef enum logic {
    RIdle = 1'b0,
    RHeld = 1'b1
  } r_state_e;

endpackage

// File: rtl/slot_pointer.sv
// Slot base-address accumulator: steps by SLOT_SIZE and wraps after the last slot.
module slot_pointer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 18,
  parameter int unsigned SLOT_SIZE  = 1920
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] base
);

  localparam logic [ADDR_WIDTH-1:0] LastBase = ADDR_WIDTH'((NUM_SLOTS - 1) * SLOT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] Step     = ADDR_WIDTH'(SLOT_SIZE);

  logic [ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
    end else if (clear) begin
      base_q <= '0;
    end else if (advance) begin
      base_q <= (base_q == LastBase) ? '0 : base_q + Step;
    end
  end

  assign base = base_q;

endmodule

// File: rtl/slice_ring_scheduler.sv
// Ring-of-slots arbiter between the RGB capture writer and the LED driver reader.
module slice_ring_scheduler #(
  parameter int unsigned RAM_ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLOTS      = slice_sched_pkg::NUM_SLOTS,
  parameter int unsigned SLOT_SIZE      = slice_sched_pkg::SLOT_SIZE,
  parameter int unsigned PREFILL        = 1,
  localparam int unsigned FILL_WIDTH    = $clog2(NUM_SLOTS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      wr_req,
  output logic                      wr_grant,
  output logic [RAM_ADDR_WIDTH-1:0] wr_base,
  input  logic                      wr_done,
  input  logic                      rd_req,
  output logic                      rd_grant,
  output logic [RAM_ADDR_WIDTH-1:0] rd_base,
  input  logic                      rd_done,
  output logic [FILL_WIDTH-1:0]     fill_level,
  output logic                      stream_ready,
  output logic                      underrun
);

  import slice_sched_pkg::*;

  localparam logic [FILL_WIDTH-1:0] FullLevel    = FILL_WIDTH'(NUM_SLOTS);
  localparam logic [FILL_WIDTH-1:0] PrefillLevel = FILL_WIDTH'(PREFILL);

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  wr_grant_q;
  logic                  rd_grant_q;
  logic [FILL_WIDTH-1:0] fill_q;
  logic                  stream_ready_q;
  logic                  underrun_q;

  logic wr_commit;
  logic rd_release;
  logic ring_full;
  logic ring_empty;

  always_comb begin
    ring_full  = (fill_q == FullLevel);
    ring_empty = (fill_q == '0);
    // Done pulses only count while the matching grant is held; flush discards them.
    wr_commit  = (w_state_q == WHeld) && wr_done && !flush;
    rd_release = (r_state_q == RHeld) && rd_done && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= WIdle;
      wr_grant_q <= 1'b0;
    end else if (flush) begin
      w_state_q  <= WIdle;
      wr_grant_q <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (wr_req && enable && !ring_full) begin
            w_state_q  <= WHeld;
            wr_grant_q <= 1'b1;
          end
        end
        WHeld: begin
          if (wr_done) begin
            w_state_q  <= WIdle;
            wr_grant_q <= 1'b0;
          end
        end
        default: begin
          w_state_q  <= WIdle;
          wr_grant_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q  <= RIdle;
      rd_grant_q <= 1'b0;
    end else if (flush) begin
      r_state_q  <= RIdle;
      rd_grant_q <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (rd_req && enable && !ring_empty) begin
            r_state_q  <= RHeld;
            rd_grant_q <= 1'b1;
          end
        end
        RHeld: begin
          if (rd_done) begin
            r_state_q  <= RIdle;
            rd_grant_q <= 1'b0;
          end
        end
        default: begin
          r_state_q  <= RIdle;
          rd_grant_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q         <= '0;
      stream_ready_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else if (flush) begin
      fill_q         <= '0;
      stream_ready_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      // Simultaneous commit and release leave the level unchanged.
      case ({wr_commit, rd_release})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      if (fill_q >= PrefillLevel) begin
        stream_ready_q <= 1'b1;
      end
      underrun_q <= rd_req && ring_empty && stream_ready_q;
    end
  end

  slot_pointer #(
    .ADDR_WIDTH (RAM_ADDR_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_SIZE  (SLOT_SIZE)
  ) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (wr_commit),
    .clear   (flush),
    .base    (wr_base)
  );

  slot_pointer #(
    .ADDR_WIDTH (RAM_ADDR_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_SIZE  (SLOT_SIZE)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (rd_release),
    .clear   (flush),
    .base    (rd_base)
  );

  assign wr_grant     = wr_grant_q;
  assign rd_grant     = rd_grant_q;
  assign fill_level   = fill_q;
  assign stream_ready = stream_ready_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/slice_ring_scheduler.md
Name: slice_ring_scheduler

Overview:
Owns the slice frame buffer in RAM as a ring of NUM_SLOTS fixed-size slots. It arbitrates slot ownership between one producer (the RGB capture writer) and one consumer (the LED driver reader side). It hands out slot base addresses and tracks fill level. It raises stream_ready once PREFILL slices are committed and flags underrun. The block sits between the RGB write logic, the display read path and the SPI-controlled enable/flush.

Parameters:
RAM_ADDR_WIDTH, 32, width of slot base address outputs
NUM_SLOTS, 18, number of slice slots in RAM
SLOT_SIZE, 1920, words per slot (40x48 image)
PREFILL, 1, committed slots required before stream_ready rises (1..NUM_SLOTS)

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous active-high reset
enable  in  1  scheduler enabled (from SPI config); low blocks new grants
flush  in  1  synchronous clear pulse; empties the ring
wr_req  in  1  producer requests a free slot
wr_grant  out  1  producer owns the slot at wr_base
wr_base  out  RAM_ADDR_WIDTH  base address of producer slot
wr_done  in  1  producer commits its slot (1-cycle pulse)
rd_req  in  1  consumer requests a filled slot
rd_grant  out  1  consumer owns the slot at rd_base
rd_base  out  RAM_ADDR_WIDTH  base address of consumer slot
rd_done  in  1  consumer releases its slot (1-cycle pulse)
fill_level  out  $clog2(NUM_SLOTS+1)  committed, unreleased slots, including any slot held by the consumer
stream_ready  out  1  prefill reached; sticky
underrun  out  1  1-cycle pulse: rd_req while ring empty and stream_ready high

Behaviour:
- Reset (async, rst=1): wr_grant=0, rd_grant=0, wr_base=0, rd_base=0, fill_level=0, stream_ready=0, underrun=0, both FSMs in IDLE.
- Write FSM, states W_IDLE and W_HELD:
  - W_IDLE -> W_HELD when wr_req & enable & fill_level < NUM_SLOTS. wr_grant rises the next cycle, so latency is 1.
  - W_HELD -> W_IDLE on wr_done. In the same edge: fill_level +1, wr_base advances by SLOT_SIZE, and wrap-around to 0 occurs after slot NUM_SLOTS-1.
- Read FSM, states R_IDLE and R_HELD:
  - R_IDLE -> R_HELD when rd_req & enable & fill_level > 0. rd_grant rises the next cycle.
  - R_HELD -> R_IDLE on rd_done. In the same edge: fill_level -1 and rd_base advances with the same wrap rule.
- Base addresses are held in accumulators, with no multiplier: next = (base == (NUM_SLOTS-1)*SLOT_SIZE) ? 0 : base + SLOT_SIZE.
- wr_base and rd_base are stable for the whole time the corresponding grant is high.
- A grant is held until its done pulse. Deasserting req while granted has no effect.
- wr_done or rd_done without the matching grant is ignored: no counter change.
- Simultaneous wr_done and rd_done: fill_level unchanged and both bases advance.
- Full ring (fill_level == NUM_SLOTS): the producer stalls in W_IDLE with no grant. No overwrite.
- Empty ring: the consumer stalls with no grant. If stream_ready=1, underrun pulses for 1 cycle. Underrun repeats every cycle rd_req stays high while the ring is still empty.
- stream_ready rises the cycle after fill_level first reaches >= PREFILL. It stays high until flush or rst; underrun does not clear it.
- enable low: no new grants. Grants already held complete normally.
- flush, which has priority over all other events in its cycle:
  - both FSMs go to IDLE and both grants drop the next cycle;
  - wr_base = rd_base = 0, fill_level = 0, stream_ready = 0;
  - a done pulse in the same cycle is discarded.
- rst mid-operation: immediate return to reset values. Partial slot contents are abandoned.
- fill_level never exceeds NUM_SLOTS and never underflows; the bench asserts both.

Decomposition:
- Package slice_sched_pkg holds:
  - the W_IDLE/W_HELD and R_IDLE/R_HELD enum typedefs;
  - the default geometry constants IMAGE_WIDTH=40, IMAGE_HEIGHT=48, SLOT_SIZE=1920, NUM_SLOTS=18.
- One sub-module, slot_pointer: holds the base accumulator with wrap and clear, and advance/flush inputs. It is instantiated twice, once for the writer and once for the reader.

Test Plan:
- Reset and prefill: rst pulse, enable=1, wr_req=1 -> wr_grant=1 at cycle 1 with wr_base=0. wr_done -> fill_level=1, stream_ready=1 next cycle (PREFILL=1), wr_base=1920.
- Fill to full with NUM_SLOTS=4: four commit cycles -> wr_base sequence 0, 1920, 3840, 5760, then 0. Fifth wr_req -> no wr_grant while fill_level=4.
- Read and wrap: from full, 5 read/release cycles with one refill -> rd_base sequence 0, 1920, 3840, 5760, 0. fill_level decrements correctly.
- Simultaneous wr_done and rd_done at fill_level=2 -> fill_level stays 2, both bases advance by 1920.
- Underrun: stream_ready=1, ring empty, rd_req held 3 cycles -> underrun high on 3 cycles, rd_grant stays 0. Then a write commit -> rd_grant=1 next cycle at the correct rd_base.
- Flush and stray done: both grants held, flush pulse coincident with wr_done -> next cycle grants=0, fill_level=0, bases=0, stream_ready=0. A stray rd_done afterwards -> no change.
